// File: rtl/axis_bram_pkg.sv
// Shared types and defaults for the AXIS<->BRAM job controller.
package axis_bram_pkg;

  localparam int unsigned DefAddrW       = 12;
  localparam int unsigned DefWordsPerRow = 36;
  localparam int unsigned DefCntW        = 18;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  typedef struct packed {
    logic                rw;
    logic [DefAddrW-1:0] start;
    logic [DefAddrW-1:0] bound;
  } cmd_t;

endpackage

// File: rtl/axis_bram_cmd_fifo.sv
// Synchronous first-word-fall-through command queue with full/empty flags.
module axis_bram_cmd_fifo
  import axis_bram_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t pop_data,
  output logic full,
  output logic empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  cmd_t            mem [DEPTH];
  logic [PtrW:0]   wr_ptr_q;
  logic [PtrW:0]   rd_ptr_q;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop_data = mem[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr_q[PtrW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axis_bram_job_ctrl.sv
// Job sequencer: queues row-range commands, programs the adapter, gates one stream
// per job, counts beats until tlast and reports a completion status.
module axis_bram_job_ctrl
  import axis_bram_pkg::*;
#(
  parameter int unsigned ADDR_W        = DefAddrW,
  parameter int unsigned WORDS_PER_ROW = DefWordsPerRow,
  parameter int unsigned CNT_W         = DefCntW,
  parameter int unsigned CMD_DEPTH     = 4
) (
  input  logic              s00_axis_aclk,
  input  logic              s00_axis_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_start_addr,
  input  logic [ADDR_W-1:0] cmd_bound_addr,
  input  logic              abort,
  output logic              rw,
  output logic              addr_reload,
  output logic [ADDR_W-1:0] bram_start_addr,
  output logic [ADDR_W-1:0] bram_bound_addr,
  output logic              s_gate,
  output logic              m_gate,
  input  logic              mon_s_tvalid,
  input  logic              mon_s_tready,
  input  logic              mon_s_tlast,
  input  logic              mon_m_tvalid,
  input  logic              mon_m_tready,
  input  logic              mon_m_tlast,
  output logic              busy,
  output logic              done,
  output logic              done_err,
  output logic [CNT_W-1:0]  done_beats
);

  cmd_t              push_cmd;
  cmd_t              fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  state_e            state_q;
  logic              staged_q;
  cmd_t              cur_q;
  logic [CNT_W-1:0]  expected_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic              rw_q;
  logic              reload_q;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] bound_q;
  logic              s_gate_q;
  logic              m_gate_q;
  logic              busy_q;
  logic              done_q;
  logic              done_err_q;
  logic [CNT_W-1:0]  done_beats_q;

  logic              beat;
  logic              last;
  logic              finish;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  rows;

  assign push_cmd = '{rw: cmd_rw, start: cmd_start_addr, bound: cmd_bound_addr};
  assign cmd_ready = !fifo_full;

  axis_bram_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (s00_axis_aclk),
    .rst_n     (s00_axis_aresetn),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The command is latched one cycle ahead of LOAD so the row-count multiply is registered.
  assign pop     = ((state_q == StIdle) || (state_q == StDone)) && !staged_q && !fifo_empty;
  assign beat    = rw_q ? (mon_s_tvalid && mon_s_tready) : (mon_m_tvalid && mon_m_tready);
  assign last    = rw_q ? mon_s_tlast : mon_m_tlast;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign finish  = beat && (last || (cnt_inc == expected_q));
  assign rows    = CNT_W'(cur_q.bound) - CNT_W'(cur_q.start) + CNT_W'(1);

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state_q      <= StIdle;
      staged_q     <= 1'b0;
      cur_q        <= '0;
      expected_q   <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      rw_q         <= 1'b0;
      reload_q     <= 1'b0;
      start_q      <= '0;
      bound_q      <= '0;
      s_gate_q     <= 1'b0;
      m_gate_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
      done_beats_q <= '0;
    end else begin
      reload_q     <= 1'b0;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
      done_beats_q <= '0;
      if (pop) begin
        cur_q    <= fifo_head;
        staged_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (staged_q) begin
            staged_q <= 1'b0;
            cnt_q    <= '0;
            if (cur_q.bound < cur_q.start) begin
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              err_q      <= 1'b0;
              expected_q <= rows * CNT_W'(WORDS_PER_ROW);
              rw_q       <= cur_q.rw;
              start_q    <= cur_q.start;
              bound_q    <= cur_q.bound;
              reload_q   <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= StLoad;
            end
          end
        end
        StLoad: begin
          s_gate_q <= rw_q;
          m_gate_q <= !rw_q;
          state_q  <= StRun;
        end
        StRun: begin
          if (beat) cnt_q <= cnt_inc;
          if (abort || finish) begin
            // Clean only when tlast lands exactly on the expected count.
            err_q    <= abort || !beat || !last || (cnt_inc != expected_q);
            s_gate_q <= 1'b0;
            m_gate_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= StDone;
          end
        end
        StDone: begin
          done_q       <= 1'b1;
          done_err_q   <= err_q;
          done_beats_q <= cnt_q;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  assign rw              = rw_q;
  assign addr_reload     = reload_q;
  assign bram_start_addr = start_q;
  assign bram_bound_addr = bound_q;
  assign s_gate          = s_gate_q;
  assign m_gate          = m_gate_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign done_err        = done_err_q;
  assign done_beats      = done_beats_q;

endmodule

// File: tb/tb_axis_bram_job_ctrl.sv
// Self-checking bench for axis_bram_job_ctrl with a row-range/beat-count reference model.
module tb_axis_bram_job_ctrl;

  localparam int WPR = 36;

  typedef struct {
    bit rw;
    int s;
    int b;
    int cyc;
  } rl_t;

  typedef struct {
    bit err;
    int beats;
    int cyc;
  } dn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [11:0] cmd_start;
  logic [11:0] cmd_bound;
  logic        abort;
  logic        rw;
  logic        addr_reload;
  logic [11:0] bram_start_addr;
  logic [11:0] bram_bound_addr;
  logic        s_gate;
  logic        m_gate;
  logic        busy;
  logic        done;
  logic        done_err;
  logic [17:0] done_beats;

  logic s_vld, s_rdy, s_last, s_raw;
  logic m_vld, m_rdy, m_last, m_raw;
  logic mon_s_tvalid, mon_s_tready, mon_s_tlast;
  logic mon_m_tvalid, mon_m_tready, mon_m_tlast;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  push_cyc = 0;
  rl_t rl_q[$];
  dn_t dn_q[$];

  // Integration-style gating; the raw flags let the bench inject traffic on a closed side.
  assign mon_s_tvalid = s_vld & (s_gate | s_raw);
  assign mon_s_tready = s_rdy & (s_gate | s_raw);
  assign mon_s_tlast  = s_last;
  assign mon_m_tvalid = m_vld & (m_gate | m_raw);
  assign mon_m_tready = m_rdy & (m_gate | m_raw);
  assign mon_m_tlast  = m_last;

  axis_bram_job_ctrl dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_rw           (cmd_rw),
    .cmd_start_addr   (cmd_start),
    .cmd_bound_addr   (cmd_bound),
    .abort            (abort),
    .rw               (rw),
    .addr_reload      (addr_reload),
    .bram_start_addr  (bram_start_addr),
    .bram_bound_addr  (bram_bound_addr),
    .s_gate           (s_gate),
    .m_gate           (m_gate),
    .mon_s_tvalid     (mon_s_tvalid),
    .mon_s_tready     (mon_s_tready),
    .mon_s_tlast      (mon_s_tlast),
    .mon_m_tvalid     (mon_m_tvalid),
    .mon_m_tready     (mon_m_tready),
    .mon_m_tlast      (mon_m_tlast),
    .busy             (busy),
    .done             (done),
    .done_err         (done_err),
    .done_beats       (done_beats)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (addr_reload) rl_q.push_back('{rw, int'(bram_start_addr), int'(bram_bound_addr), cyc});
      if (done) dn_q.push_back('{done_err, int'(done_beats), cyc});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic model_result(input int s, input int b, input int last_at, input int abort_at,
                              input bit aol, output bit err, output int beats);
    int  e;
    int  fin;
    bit  by_last;
    if (b < s) begin
      err = 1'b1;
      beats = 0;
    end else begin
      e = (b - s + 1) * WPR;
      fin = e;
      by_last = 1'b0;
      if (last_at > 0 && last_at <= e) begin
        fin = last_at;
        by_last = 1'b1;
      end
      if (abort_at > 0 && abort_at < fin) begin
        fin = abort_at;
        by_last = 1'b0;
      end
      beats = fin;
      err = !(by_last && fin == e && !aol);
    end
  endtask

  task automatic idle_inputs();
    s_vld = 0; s_rdy = 0; s_last = 0; s_raw = 0;
    m_vld = 0; m_rdy = 0; m_last = 0; m_raw = 0;
    abort = 0;
  endtask

  task automatic push_cmd(input bit r, input int s, input int b);
    int g = 0;
    while (!cmd_ready && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    cmd_valid = 1; cmd_rw = r; cmd_start = 12'(s); cmd_bound = 12'(b);
    @(posedge clk); #1;
    cmd_valid = 0;
    push_cyc = cyc;
  endtask

  task automatic drive_stream(input bit r, input int last_at, input int abort_at, input bit aol,
                              input bit toggle, input bit noise, output int sent,
                              output int end_edge);
    int g = 0;
    int k = 0;
    bit opened = 0;
    bit gate;
    bit rdy;
    bit lst;
    sent = 0;
    end_edge = -100;
    if (noise) begin
      if (r) m_raw = 1; else s_raw = 1;
    end
    while (g < 1000) begin
      g++;
      gate = r ? s_gate : m_gate;
      if (gate) opened = 1;
      if (opened && !gate) break;
      if (gate && abort_at > 0 && sent == abort_at) begin
        s_vld = 0; m_vld = 0; abort = 1;
        @(posedge clk); #1;
        abort = 0;
        end_edge = cyc;
        break;
      end
      rdy = toggle ? (k % 2 == 0) : 1'b1;
      if (gate) k++;
      lst = (sent + 1 == last_at);
      if (r) begin s_vld = 1; s_rdy = rdy; s_last = lst; end
      else   begin m_vld = 1; m_rdy = rdy; m_last = lst; end
      if (noise) begin
        if (r) begin m_vld = $urandom_range(0, 1); m_rdy = $urandom_range(0, 1); m_last = $urandom_range(0, 1); end
        else   begin s_vld = $urandom_range(0, 1); s_rdy = $urandom_range(0, 1); s_last = $urandom_range(0, 1); end
      end
      abort = aol && lst && rdy && gate;
      @(posedge clk); #1;
      abort = 0;
      if (gate && rdy) begin
        sent++;
        end_edge = cyc;
      end
    end
    idle_inputs();
  endtask

  task automatic run_job(input bit r, input int s, input int b, input int last_at,
                         input int abort_at, input bit aol, input bit toggle, input bit noise);
    bit  e_err;
    int  e_beats;
    int  sent;
    int  end_edge;
    int  g;
    rl_t rl;
    dn_t dn;
    model_result(s, b, last_at, abort_at, aol, e_err, e_beats);
    end_edge = -100;
    if (b >= s) begin
      g = 0;
      while (rl_q.size() == 0 && g < 40) begin @(posedge clk); #1; g++; end
      total++;
      if (rl_q.size() == 0) begin
        bad++;
        $display("FAIL reload_missing: job rw=%0d %0d..%0d got no addr_reload, required one", r, s, b);
      end else begin
        rl = rl_q.pop_front();
        if (rl.rw !== r || rl.s !== s || rl.b !== b) begin
          bad++;
          $display("FAIL reload_fields: got rw=%0d start=%0d bound=%0d, required rw=%0d start=%0d bound=%0d",
                   rl.rw, rl.s, rl.b, r, s, b);
        end
      end
      drive_stream(r, last_at, abort_at, aol, toggle, noise, sent, end_edge);
    end
    g = 0;
    while (dn_q.size() == 0 && g < 40) begin @(posedge clk); #1; g++; end
    total++;
    if (dn_q.size() == 0) begin
      bad++;
      $display("FAIL done_missing: job rw=%0d %0d..%0d no done pulse, required err=%0d beats=%0d",
               r, s, b, e_err, e_beats);
    end else begin
      dn = dn_q.pop_front();
      if (dn.err !== e_err || dn.beats !== e_beats) begin
        bad++;
        $display("FAIL done_status: job rw=%0d %0d..%0d got err=%0d beats=%0d, required err=%0d beats=%0d",
                 r, s, b, dn.err, dn.beats, e_err, e_beats);
      end
      total++;
      if (b >= s) begin
        if (dn.cyc !== end_edge + 1) begin
          bad++;
          $display("FAIL done_latency: done at edge %0d, required edge %0d", dn.cyc, end_edge + 1);
        end
      end else if (rl_q.size() != 0) begin
        bad++;
        $display("FAIL bad_cmd_reload: got %0d reloads for bound<start, required 0", rl_q.size());
      end
    end
    total++;
    if (s_gate !== 1'b0 || m_gate !== 1'b0) begin
      bad++;
      $display("FAIL gates_after_done: got s_gate=%0b m_gate=%0b, required 0 0", s_gate, m_gate);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rw, addr_reload, bram_start_addr, bram_bound_addr, s_gate, m_gate, busy, done, done_err,
         done_beats} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got nonzero outputs rw=%0b rl=%0b sa=%0d ba=%0d busy=%0b done=%0b beats=%0d, required all 0",
               rw, addr_reload, bram_start_addr, bram_bound_addr, busy, done, done_beats);
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_cmd_ready: got %0b, required 1", cmd_ready);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_job();
    int g = 0;
    push_cmd(1, 3, 7);
    while (rl_q.size() == 0 && g < 20) begin @(posedge clk); #1; g++; end
    total++;
    if (rl_q.size() == 0 || rl_q[0].cyc !== push_cyc + 2) begin
      bad++;
      $display("FAIL reload_latency: reload edge %0d, required %0d",
               (rl_q.size() == 0) ? -1 : rl_q[0].cyc, push_cyc + 2);
    end
    total++;
    if (s_gate !== 1'b1 || m_gate !== 1'b0 || busy !== 1'b1 || cyc !== push_cyc + 3) begin
      bad++;
      $display("FAIL write_gate_open: edge %0d s_gate=%0b m_gate=%0b busy=%0b, required edge %0d 1 0 1",
               cyc, s_gate, m_gate, busy, push_cyc + 3);
    end
    run_job(1, 3, 7, 180, 0, 0, 0, 0);
  endtask

  task automatic test_short_write();
    push_cmd(1, 3, 7);
    run_job(1, 3, 7, 48, 0, 0, 0, 0);
  endtask

  task automatic test_read_job();
    int g = 0;
    push_cmd(0, 0, 0);
    while (rl_q.size() == 0 && g < 20) begin @(posedge clk); #1; g++; end
    total++;
    if (m_gate !== 1'b1 || s_gate !== 1'b0) begin
      bad++;
      $display("FAIL read_gates: got m_gate=%0b s_gate=%0b, required 1 0", m_gate, s_gate);
    end
    run_job(0, 0, 0, 36, 0, 0, 1, 1);
  endtask

  task automatic test_queue();
    push_cmd(0, 9, 9);
    repeat (4) begin @(posedge clk); #1; end
    push_cmd(1, 10, 11);
    push_cmd(1, 5, 2);
    push_cmd(0, 7, 7);
    push_cmd(1, 100, 100);
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL queue_full: cmd_ready got %0b after 4 pushes, required 0", cmd_ready);
    end
    run_job(0, 9, 9, 36, 0, 0, 0, 0);
    run_job(1, 10, 11, 72, 0, 0, 0, 0);
    run_job(1, 5, 2, 0, 0, 0, 0, 0);
    run_job(0, 7, 7, 36, 0, 0, 1, 1);
    run_job(1, 100, 100, 36, 0, 0, 0, 0);
  endtask

  task automatic test_abort();
    push_cmd(1, 0, 1);
    push_cmd(0, 2, 2);
    push_cmd(1, 4, 4);
    run_job(1, 0, 1, 0, 10, 0, 0, 0);
    run_job(0, 2, 2, 36, 0, 0, 0, 0);
    run_job(1, 4, 4, 36, 0, 1, 0, 0);
  endtask

  task automatic test_random();
    bit r;
    int s;
    int b;
    int e;
    int la;
    int ab;
    bit aol;
    int sel;
    for (int i = 0; i < 24; i++) begin
      r = 1'($urandom_range(0, 1));
      s = $urandom_range(1, 4000);
      sel = $urandom_range(0, 3);
      b = (sel == 3) ? s - 1 : s + sel;
      e = (b >= s) ? (b - s + 1) * WPR : 0;
      sel = $urandom_range(0, 3);
      la = (sel == 0) ? e : (sel == 1) ? $urandom_range(1, (e > 1) ? e - 1 : 1) :
           (sel == 2) ? 0 : e + 3;
      ab = ($urandom_range(0, 4) == 0 && e > 1) ? $urandom_range(1, e - 1) : 0;
      aol = ($urandom_range(0, 7) == 0);
      push_cmd(r, s, b);
      run_job(r, s, b, la, ab, aol, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_job();
    push_cmd(1, 0, 2);
    repeat (5) begin @(posedge clk); #1; end
    s_vld = 1; s_rdy = 1;
    repeat (3) begin @(posedge clk); #1; end
    rl_q.delete();
    rst_n = 0;
    @(posedge clk); #1;
    idle_inputs();
    total++;
    if ({rw, addr_reload, bram_start_addr, bram_bound_addr, s_gate, m_gate, busy, done, done_err,
         done_beats} !== '0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL midjob_reset: got s_gate=%0b busy=%0b done=%0b sa=%0d cmd_ready=%0b, required zeros and cmd_ready=1",
               s_gate, busy, done, bram_start_addr, cmd_ready);
    end
    @(posedge clk); #1;
    rst_n = 1;
    repeat (12) begin @(posedge clk); #1; end
    total++;
    if (dn_q.size() != 0 || rl_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midjob_after: got done=%0d reloads=%0d busy=%0b, required 0 0 0",
               dn_q.size(), rl_q.size(), busy);
    end
  endtask

  initial begin
    cmd_valid = 0; cmd_rw = 0; cmd_start = '0; cmd_bound = '0;
    idle_inputs();
    test_reset();
    test_write_job();
    test_short_write();
    test_read_job();
    test_queue();
    test_abort();
    test_random();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_bram_job_ctrl.md
Name: axis_bram_job_ctrl

Overview:
- Job sequencer for the AXIS↔BRAM adapter.
- Queues transfer commands (direction, start row, bound row) and drives the adapter's rw / addr_reload / bram_start_addr / bram_bound_addr.
- Opens the relevant stream gate for one job at a time, counts stream beats until tlast, then reports completion status.
- Sits between the system configuration/control logic and the adapter, on the adapter's clock.

Parameters:
- ADDR_W, 12, BRAM row address width.
- WORDS_PER_ROW, 36, 32-bit beats per BRAM row (1152/32).
- CNT_W, 18, beat counter width; must be ≥ ceil(log2(2^ADDR_W*WORDS_PER_ROW)).
- CMD_DEPTH, 4, command queue depth; power of two, ≥2.

Ports:
- s00_axis_aclk  in  1  sole clock.
- s00_axis_aresetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue not full.
- cmd_rw  in  1  1 = AXIS-in→BRAM write job; 0 = BRAM→AXIS-out read job.
- cmd_start_addr  in  ADDR_W  first row.
- cmd_bound_addr  in  ADDR_W  last row, inclusive.
- abort  in  1  terminate the current job.
- rw  out  1  to adapter.
- addr_reload  out  1  to adapter; one-cycle pulse per job.
- bram_start_addr  out  ADDR_W  to adapter.
- bram_bound_addr  out  ADDR_W  to adapter.
- s_gate  out  1  enables s00 valid/ready at integration (AND).
- m_gate  out  1  enables m00 valid/ready at integration (AND).
- mon_s_tvalid, mon_s_tready, mon_s_tlast  in  1 each  adapter slave-side monitor.
- mon_m_tvalid, mon_m_tready, mon_m_tlast  in  1 each  adapter master-side monitor.
- busy  out  1  job in LOAD or RUN.
- done  out  1  one-cycle completion pulse.
- done_err  out  1  status qualified by done.
- done_beats  out  CNT_W  beats transferred, qualified by done.

Behaviour:
- Clocking/reset: single clock; reset is synchronous and active-low.
- Reset values: all outputs 0, except cmd_ready=1. The queue is flushed and the FSM enters IDLE.
- Reset mid-job: the job is dropped, with no done pulse.
- Queue
  - FIFO of {rw, start, bound}; push when cmd_valid && cmd_ready.
  - Push and pop in the same cycle are legal, including when full (cmd_ready still reflects the pre-pop full flag).
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: if queue non-empty, pop.
    - If bound < start, go to DONE with err=1 and beats=0; no reload is issued.
    - Otherwise register the command and go to LOAD. expected = (bound−start+1)*WORDS_PER_ROW, computed in CNT_W bits.
  - LOAD (exactly 1 cycle): addr_reload=1. rw and both address outputs are already stable and stay stable until the next LOAD. Next state RUN.
  - RUN
    - s_gate = rw; m_gate = !rw. The beat counter increments on the active side's tvalid && tready (s side when rw=1, m side when rw=0); the inactive side is ignored.
    - A beat with tlast: count includes that beat; go to DONE; err = (count != expected).
    - Counter reaching expected without tlast: go to DONE with err=1, overflow guarded.
    - abort: go to DONE with err=1. An abort in the same cycle as a tlast beat still counts the beat; err=1.
  - DONE (1 cycle)
    - Gates closed; done=1 with done_err and done_beats valid this cycle only.
    - Next state IDLE; the next job's LOAD can therefore start 2 cycles after DONE.
- busy=1 in LOAD and RUN.
- Latency: a command pushed at edge k into an empty queue with the FSM in IDLE:
  - addr_reload is high from edge k+2 to k+3.
  - The gate opens at edge k+3.
  - done rises one edge after the last beat's edge.
- All adapter-facing outputs are registered. abort is ignored outside RUN.

Decomposition:
- Shared package axis_bram_pkg: ADDR_W, WORDS_PER_ROW, CNT_W defaults, the FSM state enum, and the command struct {rw, start, bound}.
- One sub-module, axis_bram_cmd_fifo: synchronous, parameterised depth, full/empty flags, first-word-fall-through output.

Test Plan:
- Write job: rw=1, start=3, bound=7 → addr_reload pulses once with rw=1, start=3, bound=7. 180 s-beats are sent, tlast on beat 180 → done with err=0, beats=180; s_gate closes.
- Short write: rw=1, start=3, bound=7, tlast on beat 48 → done with err=1, beats=48.
- Read job: rw=0, start=0, bound=0 → m_gate=1, s_gate=0. 36 m-beats with ready toggling 1,0,1,… and tlast on 36 → err=0, beats=36; s-side activity is ignored.
- Queue: push 4 commands back-to-back → cmd_ready drops after the 4th. All 4 execute in order with one addr_reload each; a pushed command with bound=2 < start=5 → done err=1, beats=0, no reload.
- Abort after 10 beats of a start=0, bound=1 write → done err=1, beats=10; the next queued job proceeds normally.
- Reset asserted mid-RUN → next cycle all outputs 0, cmd_ready=1, no done pulse, queue empty.
